// File: rtl/ps2_keyboard_tx.sv
// Keyboard-side PS/2 transmitter: buffers scan codes in a FIFO and serialises 11-bit frames on ps2_clk/ps2_data.
// Optional macro PS2_BREAK_EXPAND_EN: FIFO entries carry a break flag that expands into an 0xF0 prefix frame.
module ps2_keyboard_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  input  logic                        in_break,
  output logic                        in_ready,
  output logic                        ps2_clk,
  output logic                        ps2_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  frames_sent
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FRM_W   = 11;
  localparam int unsigned IDX_W   = 4;
`ifdef PS2_BREAK_EXPAND_EN
  localparam int unsigned ENT_W   = 9;
`else
  localparam int unsigned ENT_W   = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [FRM_W-1:0] shreg, shreg_nx;
  logic             ps2_clk_nx, ps2_data_nx, busy_nx, in_ready_nx;
  logic [LVL_W-1:0] fifo_level_nx;
  logic [7:0]       frames_sent_nx;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ENT_W-1:0] rd_entry, wr_entry;
  logic             push_c, pop_c, start_c;
  logic [7:0]       tx_byte_c;

`ifdef PS2_BREAK_EXPAND_EN
  logic             pend_valid, pend_valid_nx;
  logic [7:0]       pend_code, pend_code_nx;
  assign wr_entry = {in_break, in_data};
`else
  logic             unused_in_break;
  assign unused_in_break = in_break;
  assign wr_entry = in_data;
`endif

  assign push_c   = in_valid && in_ready;
  assign rd_entry = mem[rd_ptr];

  // Frame bits in transmit order, bit 0 first: start, data LSB..MSB, odd parity, stop.
  function automatic logic [FRM_W-1:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    idx_nx         = idx;
    shreg_nx       = shreg;
    ps2_clk_nx     = ps2_clk;
    ps2_data_nx    = ps2_data;
    frames_sent_nx = frames_sent;
    pop_c          = 1'b0;
    start_c        = 1'b0;
    tx_byte_c      = rd_entry[7:0];
`ifdef PS2_BREAK_EXPAND_EN
    pend_valid_nx  = pend_valid;
    pend_code_nx   = pend_code;
`endif

    unique case (state)
      S_IDLE: begin
        cnt_nx = '0;
`ifdef PS2_BREAK_EXPAND_EN
        if (pend_valid) begin
          start_c       = 1'b1;
          tx_byte_c     = pend_code;
          pend_valid_nx = 1'b0;
        end else if (fifo_level != '0) begin
          start_c = 1'b1;
          pop_c   = 1'b1;
          if (rd_entry[8]) begin
            tx_byte_c     = 8'hF0;
            pend_valid_nx = 1'b1;
            pend_code_nx  = rd_entry[7:0];
          end
        end
`else
        if (fifo_level != '0) begin
          start_c = 1'b1;
          pop_c   = 1'b1;
        end
`endif
        if (start_c) begin
          shreg_nx    = make_frame(tx_byte_c);
          idx_nx      = '0;
          ps2_data_nx = 1'b0;
          ps2_clk_nx  = 1'b1;
          state_nx    = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_nx     = '0;
          ps2_clk_nx = 1'b0;
          state_nx   = S_LOW;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_nx     = '0;
          ps2_clk_nx = 1'b1;
          // Data moves only together with the rising ps2_clk edge.
          if (idx != IDX_W'(FRM_W - 1)) begin
            idx_nx      = idx + IDX_W'(1);
            shreg_nx    = {1'b1, shreg[FRM_W-1:1]};
            ps2_data_nx = shreg[1];
            state_nx    = S_HIGH;
          end else begin
            ps2_data_nx    = 1'b1;
            frames_sent_nx = frames_sent + 8'd1;
            state_nx       = S_GAP;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase

    fifo_level_nx = fifo_level;
    if (push_c && !pop_c) begin
      fifo_level_nx = fifo_level + LVL_W'(1);
    end else if (!push_c && pop_c) begin
      fifo_level_nx = fifo_level - LVL_W'(1);
    end
    in_ready_nx = (fifo_level_nx != LVL_W'(FIFO_DEPTH));
`ifdef PS2_BREAK_EXPAND_EN
    busy_nx = (state_nx != S_IDLE) || (fifo_level_nx != '0) || pend_valid_nx;
`else
    busy_nx = (state_nx != S_IDLE) || (fifo_level_nx != '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '1;
      ps2_clk     <= 1'b1;
      ps2_data    <= 1'b1;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
      fifo_level  <= '0;
      frames_sent <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
`ifdef PS2_BREAK_EXPAND_EN
      pend_valid  <= 1'b0;
      pend_code   <= '0;
`endif
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shreg       <= shreg_nx;
      ps2_clk     <= ps2_clk_nx;
      ps2_data    <= ps2_data_nx;
      busy        <= busy_nx;
      in_ready    <= in_ready_nx;
      fifo_level  <= fifo_level_nx;
      frames_sent <= frames_sent_nx;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
`ifdef PS2_BREAK_EXPAND_EN
      pend_valid  <= pend_valid_nx;
      pend_code   <= pend_code_nx;
`endif
    end
  end

  // FIFO storage needs no reset; pointers define its contents.
  always_ff @(posedge clk) begin
    if (resetn && push_c) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: directed and random scan codes; a line-level decoder checks frames against a queue model.
`timescale 1ns/1ps
module tb_ps2_keyboard_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned GAP_CYCLES = 8;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int          FRAME_CYC  = 22 * CLK_DIV;
`ifdef PS2_BREAK_EXPAND_EN
  localparam bit EXPAND = 1'b1;
`else
  localparam bit EXPAND = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_break = 1'b0;
  logic             in_ready, ps2_clk, ps2_data, busy;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       frames_sent;

  ps2_keyboard_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .in_break(in_break),
    .in_ready(in_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
    .fifo_level(fifo_level), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  longint      cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] frame_log[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame from the protocol rules: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic void model_push(input logic [7:0] b, input logic brk);
    if (EXPAND && brk) exp_q.push_back(8'hF0);
    exp_q.push_back(b);
  endfunction

  // Line monitor: decode frames at ps2_clk falls and score them.
  logic        m_prev_clk = 1'b1, m_prev_data = 1'b1;
  logic        m_skip = 1'b1, m_have_prev = 1'b0, m_waiting = 1'b0;
  int          m_nb = 0, m_gap = 0, frames_seen = 0;
  logic [10:0] m_bits = '0;

  initial begin : monitor
    logic rise, fall, start;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_nb = 0; m_have_prev = 1'b0; m_skip = 1'b1; m_gap = 0; frames_seen = 0;
      end else if (m_skip) begin
        m_skip = 1'b0;
      end else begin
        rise  = !m_prev_clk && ps2_clk;
        fall  = m_prev_clk && !ps2_clk;
        start = m_prev_clk && ps2_clk && m_prev_data && !ps2_data && (m_nb == 0);
        if (ps2_data != m_prev_data) begin
          checks++;
          if (!(rise || start)) begin
            errors++;
            $display("FAIL data_stable: ps2_data changed to %0b with ps2_clk %0b->%0b (cycle %0d)",
                     ps2_data, m_prev_clk, ps2_clk, cyc);
          end
        end
        if (start && m_have_prev) begin
          if (m_waiting) check("gap_exact", m_gap, GAP_CYCLES + 1);
          else begin
            checks++;
            if (m_gap < GAP_CYCLES + 1) begin
              errors++;
              $display("FAIL gap_min: got %0d expected at least %0d", m_gap, GAP_CYCLES + 1);
            end
          end
        end
        if (fall) begin
          if (m_nb < 11) m_bits[m_nb] = ps2_data;
          else begin
            checks++; errors++;
            $display("FAIL extra_fall: got fall %0d expected at most 11", m_nb + 1);
          end
          m_nb++;
        end
        if (rise && m_nb == 11) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got 0x%0h expected none", m_bits);
          end else begin
            e = exp_q.pop_front();
            check("frame_bits", m_bits, model_frame(e));
          end
          frame_log.push_back(m_bits);
          frames_seen++;
          check("frames_sent", frames_sent, frames_seen % 256);
          m_nb = 0; m_gap = 0; m_have_prev = 1'b1;
          m_waiting = (exp_q.size() != 0);
        end
        if (ps2_clk && ps2_data && m_nb == 0) m_gap++;
      end
      m_prev_clk  = ps2_clk;
      m_prev_data = ps2_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer a byte and leave in_valid high; returns the cycle of the accepting edge.
  task automatic push(input logic [7:0] b, input logic brk, output longint acc);
    int t = 0;
    in_valid = 1'b1; in_data = b; in_break = brk;
    while (!in_ready && t < 3000) begin tick(1); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 3000 cycles");
      in_valid = 1'b0; acc = -1;
      return;
    end
    tick(1);
    acc = cyc;
    model_push(b, brk);
  endtask

  task automatic wait_idle();
    int t = 0;
    in_valid = 1'b0; in_break = 1'b0;
    while ((busy || exp_q.size() != 0) && t < 5000) begin tick(1); t++; end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
    end
    tick(2);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    exp_q.delete();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    longint acc, a[6];
    int     first_fall, busy_low, base;
    logic [7:0] b;

    // Reset state
    tick(3);
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_frames_sent", frames_sent, 0);
    resetn = 1'b1;
    tick(2);

    // Single 0x1C frame: latency and busy window
    push(8'h1C, 1'b0, acc);
    in_valid = 1'b0;
    first_fall = -1; busy_low = -1;
    for (int n = 1; n <= 400 && busy_low < 0; n++) begin
      tick(1);
      if (n == 1) begin
        check("start_bit_at_pop", ps2_data, 0);
        check("level_after_pop", fifo_level, 0);
      end
      if (first_fall < 0 && !ps2_clk) first_fall = n;
      if (!busy) busy_low = n;
    end
    check("first_fall_latency", first_fall, CLK_DIV + 1);
    check("busy_low_latency", busy_low, 1 + FRAME_CYC + GAP_CYCLES);
    tick(2);
    check("frame_1c_bits", frame_log[frame_log.size()-1], 11'b10000111000);
    check("frames_after_1c", frames_sent, 1);

    // Parity corners 0x00 and 0xFF
    push(8'h00, 1'b0, acc);
    push(8'hFF, 1'b0, acc);
    wait_idle();
    check("frame_00_bits", frame_log[frame_log.size()-2], 11'b11000000000);
    check("frame_ff_bits", frame_log[frame_log.size()-1], 11'b11111111110);

    // FIFO fill under continuous in_valid
    for (int i = 0; i < 5; i++) push(8'h21 + 8'(i), 1'b0, a[i]);
    check("full_level", fifo_level, FIFO_DEPTH);
    check("full_in_ready", in_ready, 0);
    push(8'h26, 1'b0, a[5]);
    for (int i = 1; i < 5; i++) check("accept_consecutive", a[i], a[0] + i);
    check("accept_after_pop", a[5], a[0] + 1 + FRAME_CYC + GAP_CYCLES + 1 + 1);
    wait_idle();

    // Reset during data bit 3 with bytes still queued
    push(8'h5A, 1'b0, acc);
    push(8'h33, 1'b0, a[0]);
    push(8'h44, 1'b0, a[1]);
    in_valid = 1'b0;
    while (cyc < acc + 36) tick(1);
    check("pre_reset_level", fifo_level, 2);
    pulse_reset();
    check("mid_rst_ps2_clk", ps2_clk, 1);
    check("mid_rst_ps2_data", ps2_data, 1);
    check("mid_rst_fifo_level", fifo_level, 0);
    check("mid_rst_frames_sent", frames_sent, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    tick(3);
    push(8'h77, 1'b0, acc);
    wait_idle();
    check("post_reset_frame", frame_log[frame_log.size()-1], model_frame(8'h77));
    check("post_reset_count", frames_sent, 1);

    // Break-flagged code
    base = int'(frames_sent);
    push(8'h1C, 1'b1, acc);
    wait_idle();
    check("break_frame_count", frames_sent, base + (EXPAND ? 2 : 1));

    // Random codes, random break flags, random idle spacing
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      push(b, 1'($urandom), acc);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick($urandom_range(1, 120));
      end
    end
    wait_idle();

    // 256 frames from reset: counter wraps to zero
    pulse_reset();
    tick(2);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      push(b, 1'b0, acc);
    end
    wait_idle();
    check("wrap_frames_seen", frames_seen, 256);
    check("wrap_frames_sent", frames_sent, 0);
    check("wrap_fifo_level", fifo_level, 0);
    check("wrap_in_ready", in_ready, 1);
    check("wrap_ps2_clk", ps2_clk, 1);
    check("wrap_ps2_data", ps2_data, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
